// File: rtl/s3_coeff_writer.sv
// Serialises 5-trit groups from the byte-to-trit stage into single-coefficient
// writes for the S3 polynomial buffer, padding the last coefficient with zero.
module s3_coeff_writer #(
  parameter int N  = 701,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_grp_valid,
  output logic          o_grp_ready,
  input  logic [9:0]    i_grp,
  output logic          o_coeff_valid,
  input  logic          i_coeff_ready,
  output logic [AW-1:0] o_coeff_addr,
  output logic [1:0]    o_coeff,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [AW-1:0] LastAddr = AW'(N - 1);
  localparam logic [AW-1:0] PenAddr  = AW'(N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_PAD,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_addr, w_addr_nx;
  logic [2:0]    r_k, w_k_nx;
  logic [9:0]    r_sreg, w_sreg_nx;
  logic          r_err, w_err_nx;
  logic [9:0]    w_grp_clean;
  logic          w_grp_bad;

  // Illegal digits 2'b11 are replaced by zero before they enter the shifter.
  always_comb begin
    w_grp_clean = i_grp;
    w_grp_bad   = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (i_grp[2*j +: 2] == 2'b11) begin
        w_grp_clean[2*j +: 2] = 2'b00;
        w_grp_bad             = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_k     <= '0;
      r_sreg  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_k     <= w_k_nx;
      r_sreg  <= w_sreg_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_addr_nx     = r_addr;
    w_k_nx        = r_k;
    w_sreg_nx     = r_sreg;
    w_err_nx      = r_err;
    o_grp_ready   = 1'b0;
    o_coeff_valid = 1'b0;
    o_coeff_addr  = '0;
    o_coeff       = 2'b00;
    o_done        = 1'b0;
    o_err         = r_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nx = S_LOAD;
          w_addr_nx  = '0;
          w_k_nx     = '0;
          w_err_nx   = 1'b0;
        end
      end
      S_LOAD: begin
        o_grp_ready = 1'b1;
        if (i_grp_valid) begin
          w_sreg_nx  = w_grp_clean;
          w_k_nx     = '0;
          w_err_nx   = r_err | w_grp_bad;
          w_state_nx = S_EMIT;
        end
      end
      S_EMIT: begin
        o_coeff_valid = 1'b1;
        o_coeff_addr  = r_addr;
        o_coeff       = r_sreg[1:0];
        if (i_coeff_ready) begin
          w_addr_nx = r_addr + 1'b1;
          w_sreg_nx = r_sreg >> 2;
          w_k_nx    = r_k + 3'd1;
          // The fifth digit closes the group; the last group hands over to the pad write.
          if (r_k == 3'd4) begin
            w_state_nx = (r_addr == PenAddr) ? S_PAD : S_LOAD;
          end
        end
      end
      S_PAD: begin
        o_coeff_valid = 1'b1;
        o_coeff_addr  = LastAddr;
        if (i_coeff_ready) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        o_done     = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_s3_coeff_writer.sv
// Self-checking bench for s3_coeff_writer: randomized groups and backpressure
// checked against an expected coefficient list derived from the trit values.
module tb_s3_coeff_writer;

  localparam int N  = 701;
  localparam int AW = 10;
  localparam int NG = (N - 1) / 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          grp_valid;
  logic          grp_ready;
  logic [9:0]    grp;
  logic          coeff_valid;
  logic          coeff_ready;
  logic [AW-1:0] coeff_addr;
  logic [1:0]    coeff;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;

  logic [9:0] groups [NG];
  int         expCoef [N];
  bit         expErr;

  typedef struct {
    int addr;
    int coef;
  } wr_t;
  wr_t got [$];

  always #5 clk = ~clk;

  s3_coeff_writer #(.N(N), .AW(AW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_grp_valid   (grp_valid),
    .o_grp_ready   (grp_ready),
    .i_grp         (grp),
    .o_coeff_valid (coeff_valid),
    .i_coeff_ready (coeff_ready),
    .o_coeff_addr  (coeff_addr),
    .o_coeff       (coeff),
    .o_done        (done),
    .o_err         (err)
  );

  // Mode 0: group i is (i mod 243) in base 3; mode 1: random value 0..242.
  // Group badGroup (if >= 0) gets digit 2 forced to the illegal code.
  task automatic build_pattern(input int mode, input int badGroup);
    int v;
    int d;
    logic [9:0] g;
    expErr = 1'b0;
    for (int i = 0; i < NG; i++) begin
      v = (mode == 0) ? (i % 243) : int'($urandom_range(0, 242));
      g = '0;
      for (int j = 0; j < 5; j++) begin
        d = v % 3;
        v = v / 3;
        expCoef[5*i + j] = d;
        g[2*j +: 2] = 2'(d);
      end
      if (i == badGroup) begin
        g[5:4] = 2'b11;
        expCoef[5*i + 2] = 0;
        expErr = 1'b1;
      end
      groups[i] = g;
    end
    expCoef[N-1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    grp_valid = 1'b0;
    coeff_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one polynomial from start to done and checks the write stream.
  // The start cycle is cycle 1, so done must be observed in cycle 843,
  // i.e. 842 cycles after the one where start was driven.
  task automatic run_poly(input bit bp, input bit spur, input bit chkTime, input string name);
    int cyc = 0;
    int doneCnt = 0;
    int doneCyc = 0;
    int gidx = 0;
    bit accPending = 1'b0;
    bit held = 1'b0;
    bit spurEmit = 1'b0;
    logic [AW-1:0] hAddr = '0;
    logic [1:0] hCoef = '0;
    got.delete();
    @(negedge clk);
    start = 1'b1;
    while (cyc < 6000 && !(doneCnt > 0 && cyc >= doneCyc + 5)) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (held) begin
        tests++;
        if (coeff_valid !== 1'b1 || coeff_addr !== hAddr || coeff !== hCoef) begin
          fails++;
          $display("[TB] FAIL %s_hold: got valid=%b addr=%0d coeff=%0d, want valid=1 addr=%0d coeff=%0d",
                   name, coeff_valid, coeff_addr, coeff, hAddr, hCoef);
        end
      end
      if (done === 1'b1) begin
        doneCnt++;
        doneCyc = cyc;
        if (spur) start = 1'b1;
      end else if (doneCnt > 0) begin
        tests++;
        if (grp_ready !== 1'b0 || coeff_valid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL %s_idle: got grp_ready=%b coeff_valid=%b, want 0 0",
                   name, grp_ready, coeff_valid);
        end
      end
      if (spur && !spurEmit && coeff_valid === 1'b1 && coeff_addr == AW'(12)) begin
        start = 1'b1;
        spurEmit = 1'b1;
      end
      if (accPending) gidx++;
      grp_valid = (gidx < NG) && (!bp || $urandom_range(0, 3) != 0);
      grp = (gidx < NG) ? groups[gidx] : 10'h3ff;
      accPending = grp_valid && (grp_ready === 1'b1);
      coeff_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (coeff_valid === 1'b1 && coeff_ready) got.push_back('{int'(coeff_addr), int'(coeff)});
      held = (coeff_valid === 1'b1) && !coeff_ready;
      hAddr = coeff_addr;
      hCoef = coeff;
    end
    grp_valid = 1'b0;
    coeff_ready = 1'b0;

    tests++;
    if (got.size() != N) begin
      fails++;
      $display("[TB] FAIL %s_count: got %0d writes, want %0d", name, got.size(), N);
    end
    for (int i = 0; i < got.size() && i < N; i++) begin
      tests++;
      if (got[i].addr != i || got[i].coef != expCoef[i]) begin
        fails++;
        $display("[TB] FAIL %s_write%0d: got addr=%0d coeff=%0d, want addr=%0d coeff=%0d",
                 name, i, got[i].addr, got[i].coef, i, expCoef[i]);
      end
    end
    tests++;
    if (doneCnt != 1) begin
      fails++;
      $display("[TB] FAIL %s_done_count: got %0d pulses, want 1", name, doneCnt);
    end
    if (chkTime) begin
      tests++;
      if (doneCyc != 842) begin
        fails++;
        $display("[TB] FAIL %s_done_time: got %0d, want 842", name, doneCyc);
      end
    end
    tests++;
    if (err !== expErr) begin
      fails++;
      $display("[TB] FAIL %s_err: got %b, want %b", name, err, expErr);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (grp_ready !== 1'b0 || coeff_valid !== 1'b0 || coeff_addr !== '0 ||
        coeff !== 2'b00 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset: got rdy=%b vld=%b addr=%0d coeff=%0d done=%b err=%b, want all 0",
               grp_ready, coeff_valid, coeff_addr, coeff, done, err);
    end
  endtask

  task automatic test_single_group();
    int exp1 [5] = '{1, 2, 0, 1, 2};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (grp_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_load_ready: got %b, want 1", grp_ready);
    end
    grp_valid = 1'b1;
    grp = 10'b10_01_00_10_01;
    @(negedge clk);
    grp_valid = 1'b0;
    coeff_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tests++;
      if (coeff_valid !== 1'b1 || grp_ready !== 1'b0 ||
          coeff_addr !== AW'(j) || coeff !== 2'(exp1[j])) begin
        fails++;
        $display("[TB] FAIL single_coef%0d: got vld=%b rdy=%b addr=%0d coeff=%0d, want vld=1 rdy=0 addr=%0d coeff=%0d",
                 j, coeff_valid, grp_ready, coeff_addr, coeff, j, exp1[j]);
      end
      @(negedge clk);
    end
    coeff_ready = 1'b0;
    tests++;
    if (grp_ready !== 1'b1 || coeff_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_reload: got rdy=%b vld=%b, want rdy=1 vld=0", grp_ready, coeff_valid);
    end
    do_reset();
  endtask

  task automatic test_full();
    build_pattern(0, -1);
    run_poly(1'b0, 1'b0, 1'b1, "full");
  endtask

  task automatic test_backpressure();
    build_pattern(0, -1);
    run_poly(1'b1, 1'b0, 1'b0, "bp");
  endtask

  task automatic test_spurious_start();
    build_pattern(1, -1);
    run_poly(1'b0, 1'b1, 1'b1, "spur");
  endtask

  task automatic test_illegal_digit();
    build_pattern(1, 7);
    run_poly(1'b1, 1'b0, 1'b0, "illegal");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (err !== 1'b0 || grp_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL illegal_clear: got err=%b rdy=%b, want err=0 rdy=1", err, grp_ready);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int gidx = 0;
    int cyc = 0;
    bit hit = 1'b0;
    build_pattern(1, -1);
    @(negedge clk);
    start = 1'b1;
    while (!hit && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      coeff_ready = 1'b1;
      if (coeff_valid === 1'b1 && coeff_addr == AW'(37)) begin
        rst = 1'b1;
        hit = 1'b1;
      end
      if (grp_valid && grp_ready === 1'b1) gidx++;
      grp_valid = (gidx < NG);
      grp = groups[gidx % NG];
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("[TB] FAIL midrst_reach: got no addr 37 within %0d cycles, want addr 37", cyc);
    end
    @(negedge clk);
    rst = 1'b0;
    grp_valid = 1'b0;
    coeff_ready = 1'b0;
    tests++;
    if (coeff_valid !== 1'b0 || grp_ready !== 1'b0 || done !== 1'b0 || coeff_addr !== '0) begin
      fails++;
      $display("[TB] FAIL midrst_state: got vld=%b rdy=%b done=%b addr=%0d, want 0 0 0 0",
               coeff_valid, grp_ready, done, coeff_addr);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (grp_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrst_idle: got rdy=%b done=%b, want 0 0", grp_ready, done);
    end
    run_poly(1'b0, 1'b0, 1'b1, "restart");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    grp_valid = 1'b0;
    grp = '0;
    coeff_ready = 1'b0;
    test_reset();
    test_single_group();
    test_full();
    test_backpressure();
    test_spurious_start();
    test_illegal_digit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s3_coeff_writer.md
Name: s3_coeff_writer

Overview:
- Downstream neighbour of the byte-to-trit conversion stage in unpack_s3.
- Accepts 10-bit groups of 5 trits, one group per converted packed byte.
- Serialises each group into single-coefficient writes with addresses for the S3 polynomial buffer.
- After (N-1)/5 groups, appends the final coefficient N-1 as zero, then signals completion.

Parameters:
- N, 701: polynomial length; (N-1) must be divisible by 5.
- AW, 10: coefficient address width; 2^AW >= N.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins unpacking one polynomial; ignored unless in IDLE.
- grp_valid  in  1  grp holds a valid 5-trit group.
- grp_ready  out  1  block accepts a group this cycle.
- grp  in  10  trits; grp[1:0] = coeff 5i (3^0 digit) ... grp[9:8] = coeff 5i+4 (3^4 digit).
- coeff_valid  out  1  coeff/coeff_addr valid.
- coeff_ready  in  1  buffer accepts the coefficient this cycle.
- coeff_addr  out  AW  coefficient index 0..N-1.
- coeff  out  2  trit value 0, 1 or 2.
- done  out  1  one-cycle pulse after coefficient N-1 is accepted.
- err  out  1  sticky flag: an illegal digit 2'b11 was received since the last start.

Behaviour:
- Reset: state IDLE. grp_ready=0, coeff_valid=0, coeff_addr=0, coeff=0, done=0, err=0. Internal addr, digit counter k and shift register are cleared.
- rst mid-operation: abort immediately, same values as above. A partially emitted group is discarded and no done is produced.
- All outputs are registered or decoded from registered state. grp_ready has no combinational path from grp_valid. coeff_valid has no combinational path from coeff_ready.
- States:
  - IDLE: all handshakes low. start=1 -> LOAD; addr=0, k=0, err=0.
  - LOAD: grp_ready=1. On grp_valid&grp_ready:
    - sreg<=grp, k<=0 -> EMIT.
    - If any of the 5 digits in grp is 2'b11, err<=1 and that digit is stored as 2'b00.
  - EMIT: coeff_valid=1, coeff=sreg[1:0], coeff_addr=addr. On coeff_ready:
    - addr<=addr+1, sreg<=sreg>>2, k<=k+1.
    - If k==4: next state is PAD when addr==N-2, otherwise LOAD.
    - Without coeff_ready: all values held stable.
  - PAD: coeff_valid=1, coeff_addr=N-1, coeff=0. On coeff_ready -> DONE.
  - DONE: done=1 for exactly one cycle, coeff_valid=0 -> IDLE.
- Latency: a group accepted at edge t presents its first coefficient from cycle t+1.
- Throughput: 5 coefficients per group, plus one LOAD bubble per group.
- Full polynomial with coeff_ready tied high: 1 + 140*6 + 1 + 1 = 843 cycles from start to done.
- Address order is strictly increasing 0..N-1 with no gaps or repeats. addr never exceeds N-1.
- start while not in IDLE is ignored. start asserted in the same cycle as done (DONE state) is also ignored.
- grp_valid outside LOAD: no capture; the upstream stage holds grp.
- err remains set through DONE and IDLE until the next accepted start.

Test Plan:
- Single group: start; grp=10'b10_01_00_10_01, coeff_ready=1.
  -> Coefficients (addr,coeff) = (0,1), (1,2), (2,0), (3,1), (4,2).
  -> grp_ready high again in the cycle after addr 4 is accepted.
- Full polynomial: 140 groups, group i = 5 digits of (i mod 243) in base 3, coeff_ready=1.
  -> 701 writes; addr 700 carries coeff=0; done pulses exactly once at cycle 843 after start; err=0.
- Backpressure: toggle coeff_ready randomly (50%).
  -> coeff/coeff_addr stable while coeff_valid & !coeff_ready; resulting write sequence identical to the no-backpressure run.
- Illegal digit: a group containing grp[5:4]=2'b11.
  -> That coefficient is written as 0, err=1 and stays 1 after done; next start clears err to 0.
- Reset mid-run: rst=1 for 1 cycle while at addr 37.
  -> Next cycle coeff_valid=0, grp_ready=0, done=0; a subsequent start restarts at addr 0.
- Spurious start: start pulsed during EMIT at addr 12, and again in the DONE cycle.
  -> No address restart; sequence continues; block returns to IDLE after done and waits.
